// File: rtl/alien_draw_arbiter_if.sv
// VGA adapter write port: one pixel per cycle while plot is high.
interface alien_draw_arbiter_if;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;

  modport master (output vga_x, vga_y, vga_colour, plot);
  modport slave  (input  vga_x, vga_y, vga_colour, plot);
endinterface

// File: rtl/alien_draw_arbiter.sv
// Round-robin owner of the VGA write port: for each moved alien, erase the old sprite box
// and paint the new one, one pixel per cycle.
module alien_draw_arbiter #(
  parameter int unsigned N_ALIEN    = 4,
  parameter int unsigned SPR_W      = 4,
  parameter int unsigned SPR_H      = 4,
  parameter logic [2:0]  SPR_COLOUR = 3'b010,
  parameter logic [2:0]  BG_COLOUR  = 3'b000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [8*N_ALIEN-1:0]   pos_x,
  input  logic [7*N_ALIEN-1:0]   pos_y,
  alien_draw_arbiter_if.master   vga,
  output logic                   busy,
  output logic [N_ALIEN-1:0]     grant
);

  localparam int unsigned IdxW = $clog2(N_ALIEN);

  typedef enum logic [1:0] {StIdle, StErase, StDraw, StDone} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   last_grant_q;
  logic [IdxW-1:0]   sel_q;
  logic [7:0]        snap_x_q;
  logic [6:0]        snap_y_q;
  logic [2:0]        col_q;
  logic [2:0]        row_q;
  logic [7:0]        drawn_x_q [N_ALIEN];
  logic [6:0]        drawn_y_q [N_ALIEN];
  logic [N_ALIEN-1:0] drawn_valid_q;

  logic [N_ALIEN-1:0] pending;
  logic               found;
  logic [IdxW-1:0]    pick;
  int unsigned        idx;

  always_comb begin
    pending = '0;
    for (int i = 0; i < N_ALIEN; i++) begin
      pending[i] = !drawn_valid_q[i] || (pos_x[8*i +: 8] != drawn_x_q[i]) ||
                   (pos_y[7*i +: 7] != drawn_y_q[i]);
    end
  end

  // First pending alien after the previous owner, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= N_ALIEN; k++) begin
      idx = (32'(last_grant_q) + k) % N_ALIEN;
      if (!found && pending[IdxW'(idx)]) begin
        found = 1'b1;
        pick  = IdxW'(idx);
      end
    end
  end

  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic       on_screen;
  logic       last_col;
  logic       last_row;

  always_comb begin
    base_x    = (state_q == StErase) ? drawn_x_q[sel_q] : snap_x_q;
    base_y    = (state_q == StErase) ? drawn_y_q[sel_q] : snap_y_q;
    pix_x     = {1'b0, base_x} + 9'(col_q);
    pix_y     = {1'b0, base_y} + 8'(row_q);
    on_screen = (pix_x < 9'd160) && (pix_y < 8'd120);
    last_col  = (col_q == 3'(SPR_W - 1));
    last_row  = (row_q == 3'(SPR_H - 1));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= StIdle;
      vga.plot       <= 1'b0;
      vga.vga_x      <= '0;
      vga.vga_y      <= '0;
      vga.vga_colour <= BG_COLOUR;
      busy           <= 1'b0;
      grant          <= '0;
      drawn_valid_q  <= '0;
      last_grant_q   <= IdxW'(N_ALIEN - 1);
      sel_q          <= '0;
      snap_x_q       <= '0;
      snap_y_q       <= '0;
      col_q          <= '0;
      row_q          <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          vga.plot <= 1'b0;
          if (found) begin
            sel_q    <= pick;
            grant    <= N_ALIEN'(1) << pick;
            snap_x_q <= pos_x[8*pick +: 8];
            snap_y_q <= pos_y[7*pick +: 7];
            col_q    <= '0;
            row_q    <= '0;
            busy     <= 1'b1;
            state_q  <= drawn_valid_q[pick] ? StErase : StDraw;
          end
        end
        StErase, StDraw: begin
          // Off-screen pixels still consume a cycle so every pass has the same length.
          vga.plot       <= on_screen;
          vga.vga_x      <= pix_x[7:0];
          vga.vga_y      <= pix_y[6:0];
          vga.vga_colour <= (state_q == StErase) ? BG_COLOUR : SPR_COLOUR;
          if (last_col) begin
            col_q <= '0;
            if (last_row) begin
              row_q   <= '0;
              state_q <= (state_q == StErase) ? StDraw : StDone;
            end else begin
              row_q <= row_q + 3'd1;
            end
          end else begin
            col_q <= col_q + 3'd1;
          end
        end
        StDone: begin
          vga.plot             <= 1'b0;
          drawn_x_q[sel_q]     <= snap_x_q;
          drawn_y_q[sel_q]     <= snap_y_q;
          drawn_valid_q[sel_q] <= 1'b1;
          last_grant_q         <= sel_q;
          grant                <= '0;
          busy                 <= 1'b0;
          state_q              <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
